instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Fetch stage of the RV32I core. Owns the PC and issues word-aligned read requests to instruction memory.
- Buffers the in-order responses in a small FIFO and hands {instr, pc} pairs to decode over a valid/ready handshake.
- Decode uses instr[31:7] from this stage for immediate generation.
- Supports control-flow redirects, including discard of stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- DEPTH, 2, FIFO entries and also the maximum in-flight requests plus buffered entries. Power of two, 2..8.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- redirect_valid  in  1  branch/jump taken; flush and refetch
- redirect_pc  in  32  new PC; bits [1:0] ignored and forced to 0
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word-aligned fetch address
- imem_rsp_valid  in  1  read data valid; in order, latency >= 1 cycle
- imem_rsp_data  in  32  instruction word
- out_valid  out  1  FIFO head valid
- out_ready  in  1  decode consumes head
- out_instr  out  32  instruction at head
- out_pc  out  32  PC of out_instr

Behaviour:
- Reset: clk and rst are the only clock/reset; one clock domain; reset is synchronous and active-high.
  - While rst=1: imem_req_valid=0, out_valid=0, out_instr=0, out_pc=0.
  - Internal state: pc=RESET_PC, rsp_pc=RESET_PC, outstanding=0, drop_cnt=0, FIFO empty.
  - Reset asserted mid-operation discards everything. Responses arriving during reset are ignored.
  - outstanding is cleared at reset. The memory is reset together with this block.
- Request issue:
  - imem_req_valid = !rst && !redirect_valid && (outstanding + fifo_count < DEPTH), using registered counts.
  - imem_req_addr = pc.
  - Request fire (valid && ready): pc <= pc + 4. outstanding increments unless a response also arrives that cycle.
  - First request is issued in the first cycle after rst deasserts.
- Response handling:
  - outstanding decrements on every imem_rsp_valid.
  - If drop_cnt > 0: drop_cnt--, data discarded.
  - Else: push {imem_rsp_data, rsp_pc} into the FIFO; rsp_pc <= rsp_pc + 4.
  - The credit rule guarantees the FIFO is never full on a push. An assertion flags any violation.
- Output:
  - out_valid = FIFO non-empty; out_instr/out_pc come from the head, registered in the FIFO.
  - Pop on out_valid && out_ready. Push and pop may occur in the same cycle; count unchanged.
  - Minimum latency from request fire to out_valid is memory latency + 1 cycle (FIFO write, then head visible).
- Redirect (priority over everything except rst):
  - FIFO flushed; out_valid=0 next cycle; any pop in the redirect cycle is ignored.
  - pc <= redirect_pc & ~3; rsp_pc <= same value.
  - No request is issued in the redirect cycle.
  - drop_cnt <= outstanding after this cycle's response is counted, i.e. outstanding - rsp_valid. All in-flight requests become stale.
  - A response arriving in the redirect cycle is discarded regardless of drop_cnt.
  - Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
- Wrap-around: pc and rsp_pc wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- Widths:
  - outstanding and drop_cnt use $clog2(DEPTH)+1 bits and never exceed DEPTH.
  - fifo_count uses the same width.

Decomposition:
- Shared package rvscc_pkg holds:
  - XLEN=32
  - INSTR_W=32
  - typedef fetch_entry_t {logic [31:0] instr; logic [31:0] pc;}
- Sub-module sync_fifo, parameterised by WIDTH and DEPTH:
  - push, pop, flush, full, empty, count, head.
  - Reusable for later pipeline buffers.
- instr_fetch holds only the PC/credit/drop logic.

Test Plan:
- Reset release, 1-cycle memory, out_ready=1:
  - Requests at 0x0, 0x4, 0x8 on consecutive cycles.
  - out_pc sequence 0x0, 0x4, 0x8 with matching instr, one per cycle after the initial 2-cycle latency.
- Backpressure: out_ready=0 for 10 cycles, DEPTH=2.
  - Exactly 2 requests issued, then imem_req_valid=0.
  - Raising out_ready resumes with no lost or duplicated pc.
- Redirect with 2 in flight (3-cycle memory), redirect_pc=0x100:
  - Both stale responses dropped.
  - Next out_pc=0x100, no out_valid between.
- redirect_pc=0x103 gives imem_req_addr=0x100.
- Redirect in the same cycle as a response and a pop:
  - Response discarded, FIFO empty next cycle.
  - Two consecutive redirects (0x200 then 0x300): first out_pc=0x300.
- pc=0xFFFF_FFF8: out_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
- Reset asserted with FIFO full and 2 in flight: outputs 0 next cycle; first request after release at RESET_PC.

Source files
------------

// File: rtl/rvscc_pkg.sv
// Shared RV32 core definitions: word sizes and the fetch->decode entry layout.
package rvscc_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    // One buffered fetch result handed to decode.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
    } fetch_entry_t;

    // Clear the byte-offset bits so an address points at a whole instruction word.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; head is read straight from the storage array.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [WIDTH-1:0]       data_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [WIDTH-1:0]       head_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Flush wins over push and pop; a pop on an empty FIFO is ignored.
    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !flush_i && (count_q != '0);

    // Next-state pointers and occupancy.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Control state: pointers and count, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data storage: no reset, only written on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Writers must never push into a full FIFO.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(do_push && full_o));

endmodule

// File: rtl/instr_fetch.sv
// RV32I fetch stage: owns the PC, issues credit-limited word fetches and
// buffers in-order responses for decode. Redirects flush the buffer and
// mark every in-flight response as stale so it is dropped on arrival.
module instr_fetch
    import rvscc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);
    localparam int           CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]  DEPTH_C = (CW+1)'(DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credits_used;
    logic            req_fire;
    logic            rsp_take;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

    // A request slot exists only while in-flight plus buffered stays below DEPTH,
    // which is what guarantees every accepted response finds room in the FIFO.
    assign credits_used   = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign imem_req_valid = !rst && !redirect_valid && (credits_used < DEPTH_C);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_take   = imem_rsp_valid && !rst;
    assign push       = rsp_take && !redirect_valid && (drop_cnt_q == '0);
    assign push_entry = '{instr: imem_rsp_data, pc: rsp_pc_q};

    assign out_valid = !rst && !fifo_empty;
    assign pop       = out_valid && out_ready && !redirect_valid;
    assign out_instr = out_valid ? head_entry.instr : '0;
    assign out_pc    = out_valid ? head_entry.pc    : '0;

    // PC, response-PC, credit and stale-drop bookkeeping; redirect overrides all.
    always_comb begin
        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_take);
        drop_cnt_d    = drop_cnt_q;
        if (redirect_valid) begin
            pc_d       = word_align(redirect_pc);
            rsp_pc_d   = word_align(redirect_pc);
            drop_cnt_d = outstanding_q - CW'(rsp_take);
        end else begin
            if (req_fire) pc_d = pc_q + 32'd4;
            if (rsp_take) begin
                if (drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - CW'(1);
                else                  rsp_pc_d   = rsp_pc_q + 32'd4;
            end
        end
    end

    // Fetch control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .data_i  (push_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .head_o  (head_entry)
    );

    // The credit rule must keep the buffer from ever overflowing.
    a_credit_ok: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: in-order fixed-latency memory model,
// expected-stream scoreboard, and directed plus randomized scenarios.
module tb_instr_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int tests_run = 0;
    int tests_failed = 0;
    int lat = 1;
    int n_out = 0;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // ---------------- memory model: in order, fixed latency 'lat' ----------
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t       mq[$];
    int          cyc = 0;
    logic        s_fire = 1'b0, s_took = 1'b0, s_rst = 1'b1;
    logic [31:0] s_addr = '0;

    always @(negedge clk) begin
        s_fire = imem_req_valid && imem_req_ready;
        s_addr = imem_req_addr;
        s_took = imem_rsp_valid;
        s_rst  = rst;
    end

    always @(posedge clk) begin
        #1;
        cyc++;
        if (s_rst) begin
            mq.delete();
        end else begin
            if (s_took && mq.size() > 0) void'(mq.pop_front());
            if (s_fire) mq.push_back('{addr: s_addr, due: cyc + lat - 1});
        end
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end
    end

    // ---------------- scoreboard: expected request and output streams ------
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] exp_req = RESET_PC;

    always @(negedge clk) begin
        if (rst) begin
            exp_pc  = RESET_PC;
            exp_req = RESET_PC;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                tests_run++;
                if (imem_req_addr !== exp_req) begin
                    tests_failed++;
                    $display("FAIL sb_req_addr: got %h expected %h", imem_req_addr, exp_req);
                end
                exp_req = exp_req + 32'd4;
            end
            if (redirect_valid) begin
                tests_run++;
                if (imem_req_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL sb_req_in_redirect: got %b expected 0", imem_req_valid);
                end
                exp_pc  = redirect_pc & ~32'h3;
                exp_req = exp_pc;
            end else if (out_valid && out_ready) begin
                tests_run++;
                if (out_pc !== exp_pc || out_instr !== mem_word(exp_pc)) begin
                    tests_failed++;
                    $display("FAIL sb_out: got pc %h instr %h expected pc %h instr %h",
                             out_pc, out_instr, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                n_out++;
            end
        end
    end

    // ---------------- helpers ----------------------------------------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int l);
        step();
        rst = 1'b1;
        redirect_valid = 1'b0;
        repeat (2) step();
        lat = l;
        rst = 1'b0;
    endtask

    // ---------------- scenarios --------------------------------------------
    task automatic test_reset();
        step();
        rst = 1'b1;
        imem_req_ready = 1'b1;
        out_ready = 1'b1;
        step();
        @(negedge clk);
        tests_run++;
        if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid); end
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        tests_run++;
        if (out_instr !== 32'h0) begin tests_failed++; $display("FAIL rst_out_instr: got %h expected 0", out_instr); end
        tests_run++;
        if (out_pc !== 32'h0) begin tests_failed++; $display("FAIL rst_out_pc: got %h expected 0", out_pc); end
        step();
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
            tests_failed++;
            $display("FAIL rst_first_req: got valid %b addr %h expected 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
        end
    endtask

    task automatic test_basic();
        int first_fire = -1;
        int first_out = -1;
        logic [31:0] fa[$];
        logic [31:0] op[$];
        imem_req_ready = 1'b1;
        out_ready = 1'b1;
        do_reset(1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin
                if (first_fire < 0) first_fire = c;
                fa.push_back(imem_req_addr);
            end
            if (out_valid) begin
                if (first_out < 0) first_out = c;
                op.push_back(out_pc);
            end
            step();
        end
        tests_run++;
        if (first_fire != 0) begin tests_failed++; $display("FAIL basic_first_fire: got cycle %0d expected 0", first_fire); end
        tests_run++;
        if (first_out - first_fire != 2) begin
            tests_failed++;
            $display("FAIL basic_latency: got %0d expected 2", first_out - first_fire);
        end
        tests_run++;
        if (fa.size() < 3 || fa[0] !== 32'h0 || fa[1] !== 32'h4 || fa[2] !== 32'h8) begin
            tests_failed++;
            $display("FAIL basic_req_seq: got %0d requests, expected 0,4,8 first", fa.size());
        end
        tests_run++;
        if (op.size() < 3 || op[0] !== 32'h0 || op[1] !== 32'h4 || op[2] !== 32'h8) begin
            tests_failed++;
            $display("FAIL basic_out_seq: got %0d outputs, expected 0,4,8 first", op.size());
        end
    endtask

    task automatic test_backpressure();
        int fires = 0;
        logic [31:0] op[$];
        imem_req_ready = 1'b1;
        out_ready = 1'b0;
        do_reset(1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) fires++;
            step();
        end
        @(negedge clk);
        tests_run++;
        if (fires != 2) begin tests_failed++; $display("FAIL bp_fire_count: got %0d expected 2", fires); end
        tests_run++;
        if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_req_stalled: got %b expected 0", imem_req_valid); end
        step();
        out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) op.push_back(out_pc);
            step();
        end
        tests_run++;
        if (op.size() < 6) begin
            tests_failed++;
            $display("FAIL bp_resume_count: got %0d expected at least 6", op.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                tests_run++;
                if (op[i] !== 32'(i * 4)) begin
                    tests_failed++;
                    $display("FAIL bp_resume_pc[%0d]: got %h expected %h", i, op[i], 32'(i * 4));
                end
            end
        end
    endtask

    task automatic test_redirect_inflight();
        logic found = 1'b0;
        logic [31:0] fpc = '0;
        logic [31:0] fin = '0;
        imem_req_ready = 1'b1;
        out_ready = 1'b1;
        do_reset(3);
        step();
        step();
        tests_run++;
        if (mq.size() != 2) begin tests_failed++; $display("FAIL rd_inflight: got %0d expected 2", mq.size()); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (out_valid) begin
                found = 1'b1;
                fpc = out_pc;
                fin = out_instr;
            end
            step();
        end
        tests_run++;
        if (!found || fpc !== 32'h100 || fin !== mem_word(32'h100)) begin
            tests_failed++;
            $display("FAIL rd_first_out: got found %b pc %h instr %h expected pc 100 instr %h", found, fpc, fin, mem_word(32'h100));
        end
    endtask

    task automatic test_redirect_unaligned();
        imem_req_ready = 1'b1;
        out_ready = 1'b1;
        do_reset(1);
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h103;
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
            tests_failed++;
            $display("FAIL unaligned_addr: got valid %b addr %h expected 1 00000100", imem_req_valid, imem_req_addr);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic hit = 1'b0;
        logic found = 1'b0;
        logic [31:0] fpc = '0;
        imem_req_ready = 1'b1;
        out_ready = 1'b1;
        do_reset(1);
        for (int c = 0; c < 20 && !hit; c++) begin
            if (imem_rsp_valid && out_valid) hit = 1'b1;
            else step();
        end
        tests_run++;
        if (!hit) begin tests_failed++; $display("FAIL b2b_collision_setup: got none expected rsp+out in one cycle"); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        step();
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_flush: got out_valid %b expected 0", out_valid); end
        redirect_pc = 32'h300;
        step();
        redirect_valid = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (out_valid) begin
                found = 1'b1;
                fpc = out_pc;
            end
            step();
        end
        tests_run++;
        if (!found || fpc !== 32'h300) begin
            tests_failed++;
            $display("FAIL b2b_first_out: got found %b pc %h expected 00000300", found, fpc);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] op[$];
        logic [31:0] exp3[3];
        exp3[0] = 32'hFFFF_FFF8;
        exp3[1] = 32'hFFFF_FFFC;
        exp3[2] = 32'h0000_0000;
        imem_req_ready = 1'b1;
        out_ready = 1'b1;
        do_reset(1);
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) op.push_back(out_pc);
            step();
        end
        tests_run++;
        if (op.size() < 3) begin
            tests_failed++;
            $display("FAIL wrap_count: got %0d expected at least 3", op.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests_run++;
                if (op[i] !== exp3[i]) begin
                    tests_failed++;
                    $display("FAIL wrap_pc[%0d]: got %h expected %h", i, op[i], exp3[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midrun();
        logic found = 1'b0;
        logic [31:0] fpc = '0;
        imem_req_ready = 1'b1;
        out_ready = 1'b0;
        do_reset(3);
        repeat (12) step();
        tests_run++;
        if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL midrst_setup: got out_valid %b expected 1", out_valid); end
        step();
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== 32'h0 || imem_req_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_outputs: got valid %b instr %h pc %h req %b expected all 0",
                     out_valid, out_instr, out_pc, imem_req_valid);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
            tests_failed++;
            $display("FAIL midrst_first_req: got valid %b addr %h expected 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
        end
        step();
        out_ready = 1'b1;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (out_valid) begin
                found = 1'b1;
                fpc = out_pc;
            end
            step();
        end
        tests_run++;
        if (!found || fpc !== RESET_PC) begin
            tests_failed++;
            $display("FAIL midrst_first_out: got found %b pc %h expected %h", found, fpc, RESET_PC);
        end
    endtask

    task automatic test_random();
        int start_out;
        for (int seg = 0; seg < 3; seg++) begin
            do_reset(int'($urandom_range(1, 4)));
            start_out = n_out;
            for (int c = 0; c < 300; c++) begin
                imem_req_ready = ($urandom_range(0, 3) != 0);
                out_ready      = ($urandom_range(0, 2) != 0);
                if ($urandom_range(0, 24) == 0) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = $urandom;
                end else begin
                    redirect_valid = 1'b0;
                end
                step();
            end
            redirect_valid = 1'b0;
            tests_run++;
            if (n_out - start_out < 20) begin
                tests_failed++;
                $display("FAIL random_progress[%0d]: got %0d outputs expected at least 20", seg, n_out - start_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_unaligned();
        test_back_to_back();
        test_wrap();
        test_reset_midrun();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
